// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset PC, instruction memory window, nop encoding,
// handshake payload widths and the address-fault predicate used by the fetch queue.
// FETCH_QUEUE_ADDR_CHECK_EN widens each queue entry by one exception bit.
package cpu_defs;

  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] IM_LAST   = 32'h0000_6FFC;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;

`ifdef FETCH_QUEUE_ADDR_CHECK_EN
  localparam int ENTRY_W = PC_W + INSTR_W + 1;
`else
  localparam int ENTRY_W = PC_W + INSTR_W;
`endif

  // A PC faults when misaligned or outside the instruction memory window.
  function automatic logic pc_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) | (pc < IM_BASE) | (pc > IM_LAST);
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: DEPTH x WIDTH registers, one synchronous
// write port and one combinational read port so the head is visible the cycle
// after it is written.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      // Each slot captures the payload when the write pointer selects it.
      always_ff @(posedge clk) begin
        if (wr_en && (wr_ptr == PTR_W'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  assign rd_data = mem_reg[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: small FIFO of {PC, instruction} pairs between fetch and decode
// with valid/ready on both sides and a flush that drops wrong-path entries.
// Optional FETCH_QUEUE_ADDR_CHECK_EN: tag each pushed entry with an
// address-fault flag and replace its instruction with a nop.
module fetch_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  output logic             out_exc,
  input  logic             out_ready,
  output logic [PTR_W:0]   count
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W:0]     count_reg, count_next;
  logic [31:0]        last_pc_reg, last_pc_next;

  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  logic [31:0]        head_pc;
  logic [31:0]        head_instr;
  logic               head_exc;

  // Readiness depends only on registered occupancy, never on out_ready.
  assign in_ready  = (count_reg < FULL_COUNT);
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

`ifdef FETCH_QUEUE_ADDR_CHECK_EN
  logic in_exc;
  assign in_exc     = pc_fault(in_pc);
  assign wr_data    = {in_exc, in_pc, (in_exc ? NOP_INSTR : in_instr)};
  assign head_exc   = rd_data[PC_W+INSTR_W];
`else
  assign wr_data    = {in_pc, in_instr};
  assign head_exc   = 1'b0;
`endif
  assign head_pc    = rd_data[PC_W+INSTR_W-1:INSTR_W];
  assign head_instr = rd_data[INSTR_W-1:0];

  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (wr_ptr_reg),
    .wr_data (wr_data),
    .rd_ptr  (rd_ptr_reg),
    .rd_data (rd_data)
  );

  // Storage is only exposed while an entry is valid; when empty show a nop
  // and the PC of the last instruction handed to decode.
  assign out_pc    = out_valid ? head_pc    : last_pc_reg;
  assign out_instr = out_valid ? head_instr : NOP_INSTR;
  assign out_exc   = out_valid & head_exc;

  // Next-state: flush wins over push/pop; pointers wrap naturally at DEPTH.
  always_comb begin
    rd_ptr_next  = rd_ptr_reg;
    wr_ptr_next  = wr_ptr_reg;
    count_next   = count_reg;
    last_pc_next = last_pc_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next  = rd_ptr_reg + 1'b1;
        last_pc_next = head_pc;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  // State registers; reset takes priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      count_reg   <= '0;
      last_pc_reg <= PC_RESET;
    end else begin
      rd_ptr_reg  <= rd_ptr_next;
      wr_ptr_reg  <= wr_ptr_next;
      count_reg   <= count_next;
      last_pc_reg <= last_pc_next;
    end
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Small synchronous FIFO of {PC, instruction} pairs between the instruction fetch unit (producer) and the decode/control stage (consumer).
- Decouples fetch from decode stalls and discards wrong-path instructions on a redirect (branch/jump taken).
- First step of the move from the single-cycle datapath to a pipelined one.
- Both sides use a valid/ready handshake.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, $clog2(DEPTH), read/write pointer width.

Ports:
- clk  input  1  clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- flush  input  1  redirect: discard all queued and incoming entries this cycle
- in_valid  input  1  fetch side has a valid {in_pc, in_instr}
- in_pc  input  32  PC of fetched instruction
- in_instr  input  32  fetched instruction word
- in_ready  output  1  queue can accept a push this cycle
- out_valid  output  1  head entry valid
- out_pc  output  32  head entry PC
- out_instr  output  32  head entry instruction
- out_exc  output  1  head entry address-fault flag (see Optional Feature)
- out_ready  input  1  decode consumes head this cycle
- count  output  PTR_W+1  current occupancy, 0..DEPTH

Behaviour:
- Clocking and reset:
  - Reset is synchronous and active-high. Clock is clk.
  - On reset: count=0, pointers=0, out_valid=0, out_pc=32'h0000_3000, out_instr=32'h0000_0000, out_exc=0, in_ready=1.
- Handshake:
  - push = in_valid & in_ready & ~flush.
  - pop = out_valid & out_ready & ~flush.
  - Producer holds in_pc/in_instr stable while in_valid=1 and in_ready=0.
- Readiness and outputs:
  - in_ready = (count < DEPTH). It is combinational from registered count only, with no dependency on out_ready, so there is no combinational path from out_ready to in_ready.
  - out_valid = (count != 0).
  - out_pc/out_instr/out_exc present the head entry combinationally from storage.
  - When empty: out_instr = 32'h0 (nop) and out_exc = 0; out_pc holds the last popped PC (0x3000 after reset).
- Latency: no bypass. An entry pushed at edge N appears at out_* after edge N, so the earliest pop is in cycle N+1.
- Simultaneous push and pop:
  - Allowed when 0 < count < DEPTH; count is unchanged and both pointers advance.
  - When count=DEPTH, in_ready=0, so only the pop occurs.
  - When count=0 there is no pop, so only the push occurs.
- Pointer wrap: pointers wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.
- Flush:
  - At the edge with flush=1: count, rd_ptr and wr_ptr return to 0, out_valid=0 from the next cycle, and any concurrent push and pop are suppressed.
  - flush takes priority over push and pop. reset takes priority over flush.
- Reset mid-operation: all queued entries are lost. Storage contents are don't-care, but must never be exposed because out_valid=0.
- Datapath: no arithmetic on data; PC is stored verbatim. count updates are saturating-free because the handshake rules prevent overflow and underflow.

Optional Feature:
- Macro: FETCH_QUEUE_ADDR_CHECK_EN.
- Defined:
  - On push, compute exc = (in_pc[1:0] != 2'b00) | (in_pc < 32'h0000_3000) | (in_pc > 32'h0000_6FFC). Store it alongside the entry.
  - out_exc reflects the head entry's flag.
  - The instruction of a faulting entry is replaced by 32'h0 on push.
- Undefined: no exc storage bit, out_exc tied 0, instructions stored unmodified.

Decomposition:
- Shared package (cpu_defs):
  - PC_RESET = 32'h0000_3000
  - IM_BASE = 32'h0000_3000
  - IM_LAST = 32'h0000_6FFC
  - NOP_INSTR = 32'h0
  - Handshake-width localparams.
- One sub-module: fetch_queue_mem, a DEPTH x (64 or 65 bit) register array with one write port (wr_en, wr_ptr) and one combinational read port (rd_ptr). fetch_queue keeps pointers, count, flush and handshake logic.

Test Plan:
- Reset, then idle with in_valid=0: out_valid=0, count=0, in_ready=1, out_pc=0x3000, out_instr=0.
- Push PCs 0x3000, 0x3004, 0x3008, 0x300C with out_ready=0:
  - count=4, in_ready=0.
  - A fifth push with PC 0x3010 is not accepted.
  - Then out_ready=1: pops occur in order 0x3000..0x300C, one per cycle.
  - count reaches 0 after 4 cycles.
- Steady stream with in_valid=1, out_ready=1 over 10 PCs from 0x3000: after the first push, count stays 1 and each PC appears exactly once in order, crossing pointer wrap twice.
- Queue holding 3 entries; assert flush together with in_valid=1 (PC 0x3040) and out_ready=1: next cycle count=0, out_valid=0, and 0x3040 is never output.
- Assert reset with count=2 and a concurrent push: next cycle count=0, out_valid=0, out_pc=0x3000.
- FETCH_QUEUE_ADDR_CHECK_EN defined:
  - Push PC 0x3002: out_exc=1, out_instr=0.
  - Push PC 0x7000: out_exc=1.
  - Push PC 0x6FFC: out_exc=0, instruction preserved.
